// File: rtl/cmac_pkg.sv
// Shared CMAC definitions: bus width defaults, RX write-side state encoding
// and the pointer-width helper used by the packet buffers.
package cmac_pkg;

    localparam int CMAC_DATA_WIDTH = 512;
    localparam int CMAC_KEEP_WIDTH = CMAC_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        ACCEPT  = 2'd1,
        DISCARD = 2'd2
    } wr_state_t;

    // One extra bit beyond the address so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// The read register only loads on rd_en so a stalled word is held.
module pkt_fifo_ram #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cmac_rx_pkt_filter.sv
// RX store-and-forward packet filter: only complete, error-free packets
// captured while PCS alignment is up are released downstream.
module cmac_rx_pkt_filter
    import cmac_pkg::*;
#(
    parameter int DATA_WIDTH = CMAC_DATA_WIDTH,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH = 256,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  user_clk,
    input  logic                  user_reset,
    input  logic                  aligned,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [CNT_WIDTH-1:0]  pkt_good_count,
    output logic [CNT_WIDTH-1:0]  pkt_drop_count
);

    localparam int PW    = ptr_width(FIFO_DEPTH);
    localparam int AW    = PW - 1;
    localparam int RAM_W = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_PTR = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    wr_state_t              state_reg, state_next;
    logic [PW-1:0]          wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]          commit_ptr_reg, commit_ptr_next;
    logic [PW-1:0]          rd_ptr_reg;
    logic [CNT_WIDTH-1:0]   good_cnt_reg, drop_cnt_reg;
    logic                   good_inc, drop_inc;
    logic                   full;
    logic                   ram_wr_en;

    logic                   rd_en;
    logic                   out_load;
    logic                   ram_valid_reg;
    logic                   out_valid_reg;
    logic [RAM_W-1:0]       ram_rd_data;
    logic [RAM_W-1:0]       out_word_reg;

    // Space is judged against the registered read pointer only.
    assign full = ((wr_ptr_reg - rd_ptr_reg) == DEPTH_PTR);

    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        commit_ptr_next = commit_ptr_reg;
        ram_wr_en       = 1'b0;
        good_inc        = 1'b0;
        drop_inc        = 1'b0;

        if (!aligned) begin
            wr_ptr_next = commit_ptr_reg;
            state_next  = SYNC;
            drop_inc    = ((state_reg == ACCEPT) && (wr_ptr_reg != commit_ptr_reg)) ||
                          (state_reg == DISCARD);
        end else if (s_axis_tvalid) begin
            case (state_reg)
                SYNC: begin
                    if (s_axis_tlast) begin
                        state_next = ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (full) begin
                        wr_ptr_next = commit_ptr_reg;
                        drop_inc    = 1'b1;
                        if (!s_axis_tlast) begin
                            state_next = DISCARD;
                        end
                    end else begin
                        ram_wr_en = 1'b1;
                        if (!s_axis_tlast) begin
                            wr_ptr_next = wr_ptr_reg + PTR_ONE;
                        end else if (!s_axis_tuser) begin
                            wr_ptr_next     = wr_ptr_reg + PTR_ONE;
                            commit_ptr_next = wr_ptr_reg + PTR_ONE;
                            good_inc        = 1'b1;
                        end else begin
                            wr_ptr_next = commit_ptr_reg;
                            drop_inc    = 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    if (s_axis_tlast) begin
                        state_next = ACCEPT;
                    end
                end
                default: begin
                    state_next = SYNC;
                end
            endcase
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state_reg      <= SYNC;
            wr_ptr_reg     <= '0;
            commit_ptr_reg <= '0;
            good_cnt_reg   <= '0;
            drop_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            commit_ptr_reg <= commit_ptr_next;
            good_cnt_reg   <= good_cnt_reg + CNT_WIDTH'(good_inc);
            drop_cnt_reg   <= drop_cnt_reg + CNT_WIDTH'(drop_inc);
        end
    end

    pkt_fifo_ram #(
        .WIDTH      (RAM_W),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk     (user_clk),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_reg[AW-1:0]),
        .rd_data (ram_rd_data)
    );

    // Two-stage read pipe: RAM read register, then the output register.
    assign out_load = ram_valid_reg && (!out_valid_reg || m_axis_tready);
    assign rd_en    = (rd_ptr_reg != commit_ptr_reg) && (!ram_valid_reg || out_load);

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            rd_ptr_reg    <= '0;
            ram_valid_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            out_word_reg  <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
                ram_valid_reg <= 1'b1;
            end else if (out_load) begin
                ram_valid_reg <= 1'b0;
            end
            if (out_load) begin
                out_valid_reg <= 1'b1;
                out_word_reg  <= ram_rd_data;
            end else if (m_axis_tready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign s_axis_tready  = 1'b1;
    assign m_axis_tdata   = out_word_reg[DATA_WIDTH-1:0];
    assign m_axis_tkeep   = out_word_reg[DATA_WIDTH +: KEEP_WIDTH];
    assign m_axis_tlast   = out_word_reg[RAM_W-1];
    assign m_axis_tvalid  = out_valid_reg;
    assign pkt_good_count = good_cnt_reg;
    assign pkt_drop_count = drop_cnt_reg;

endmodule
